// File: rtl/vga_timing_pkg.sv
// Shared VGA mode constants and helpers for the raster timing core.
package vga_timing_pkg;

  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
  } vga_axis_t;

  // 640x480 @ 60 Hz, 25 MHz pixel rate from a 50 MHz master clock
  localparam int unsigned VGA640_H_ACTIVE = 640;
  localparam int unsigned VGA640_H_FP     = 16;
  localparam int unsigned VGA640_H_SYNC   = 96;
  localparam int unsigned VGA640_H_BP     = 48;
  localparam int unsigned VGA640_V_ACTIVE = 480;
  localparam int unsigned VGA640_V_FP     = 10;
  localparam int unsigned VGA640_V_SYNC   = 2;
  localparam int unsigned VGA640_V_BP     = 33;
  localparam bit          VGA640_HS_POL   = 1'b0;
  localparam bit          VGA640_VS_POL   = 1'b0;
  localparam int unsigned VGA640_CLK_DIV  = 2;

  // 800x600 @ 72 Hz, 50 MHz pixel rate from a 50 MHz master clock
  localparam int unsigned VGA800_H_ACTIVE = 800;
  localparam int unsigned VGA800_H_FP     = 56;
  localparam int unsigned VGA800_H_SYNC   = 120;
  localparam int unsigned VGA800_H_BP     = 64;
  localparam int unsigned VGA800_V_ACTIVE = 600;
  localparam int unsigned VGA800_V_FP     = 37;
  localparam int unsigned VGA800_V_SYNC   = 6;
  localparam int unsigned VGA800_V_BP     = 23;
  localparam bit          VGA800_HS_POL   = 1'b1;
  localparam bit          VGA800_VS_POL   = 1'b1;
  localparam int unsigned VGA800_CLK_DIV  = 1;

  localparam vga_axis_t VGA640_H = '{active: VGA640_H_ACTIVE, fp: VGA640_H_FP,
                                     sync: VGA640_H_SYNC, bp: VGA640_H_BP};
  localparam vga_axis_t VGA640_V = '{active: VGA640_V_ACTIVE, fp: VGA640_V_FP,
                                     sync: VGA640_V_SYNC, bp: VGA640_V_BP};
  localparam vga_axis_t VGA800_H = '{active: VGA800_H_ACTIVE, fp: VGA800_H_FP,
                                     sync: VGA800_H_SYNC, bp: VGA800_H_BP};
  localparam vga_axis_t VGA800_V = '{active: VGA800_V_ACTIVE, fp: VGA800_V_FP,
                                     sync: VGA800_V_SYNC, bp: VGA800_V_BP};

  function automatic int unsigned vga_total(input int unsigned active,
                                            input int unsigned fp,
                                            input int unsigned sync,
                                            input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_sig_delay.sv
// WIDTH x DEPTH shift register advancing on ce; DEPTH=0 is a plain wire.
module vga_sig_delay #(
  parameter int unsigned     WIDTH   = 3,
  parameter int unsigned     DEPTH   = 0,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ctl;
    assign unused_ctl = ^{clk, clr_n, ce};
    assign q = d;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
      for (int unsigned i = 0; i < DEPTH; i++) stage_d[i] = stage_q[i];
      if (ce) begin
        stage_d[0] = d;
        for (int unsigned i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
      end
    end

    always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
        for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
      end else begin
        for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= stage_d[i];
      end
    end

    assign q = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_core.sv
// Parametrised VGA raster timing: pixel-tick divider, h/v counters,
// sync/DE decode with pipeline-matching delay, blanked colour output.
module vga_timing_core
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA640_H_ACTIVE,
  parameter int unsigned H_FP     = VGA640_H_FP,
  parameter int unsigned H_SYNC   = VGA640_H_SYNC,
  parameter int unsigned H_BP     = VGA640_H_BP,
  parameter int unsigned V_ACTIVE = VGA640_V_ACTIVE,
  parameter int unsigned V_FP     = VGA640_V_FP,
  parameter int unsigned V_SYNC   = VGA640_V_SYNC,
  parameter int unsigned V_BP     = VGA640_V_BP,
  parameter bit          HS_POL   = VGA640_HS_POL,
  parameter bit          VS_POL   = VGA640_VS_POL,
  parameter int unsigned CLK_DIV  = VGA640_CLK_DIV,
  parameter int unsigned PIPE_LAT = 0,
  parameter int unsigned CW       = 10,
  parameter int unsigned R_W      = 3,
  parameter int unsigned G_W      = 3,
  parameter int unsigned B_W      = 2
) (
  input  logic           clk,
  input  logic           clr_n,
  input  logic [R_W-1:0] i_red,
  input  logic [G_W-1:0] i_green,
  input  logic [B_W-1:0] i_blue,
  output logic [CW-1:0]  h,
  output logic [CW-1:0]  v,
  output logic           pix_ce,
  output logic           line_start,
  output logic           frame_start,
  output logic [7:0]     frame_cnt,
  output logic           hsync,
  output logic           vsync,
  output logic           de,
  output logic [R_W-1:0] red,
  output logic [G_W-1:0] green,
  output logic [B_W-1:0] blue
);

  localparam int unsigned H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

  if (((H_TOTAL - 1) >> CW) != 0 || ((V_TOTAL - 1) >> CW) != 0) begin : g_chk_cw
    $error("vga_timing_core: CW=%0d too narrow for H_TOTAL=%0d / V_TOTAL=%0d", CW, H_TOTAL, V_TOTAL);
  end
  if (CLK_DIV < 1) begin : g_chk_div
    $error("vga_timing_core: CLK_DIV must be >= 1");
  end
  if (PIPE_LAT > 4) begin : g_chk_lat
    $error("vga_timing_core: PIPE_LAT must be 0..4");
  end
  if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_chk_porch
    $error("vga_timing_core: porch and sync widths must be >= 1");
  end

  logic [DW-1:0]  div_q, div_d;
  logic           run_q, run_d;
  logic [CW-1:0]  h_q, h_d, v_q, v_d;
  logic [7:0]     fc_q, fc_d;
  logic           hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic [R_W-1:0] red_q, red_d;
  logic [G_W-1:0] green_q, green_d;
  logic [B_W-1:0] blue_q, blue_d;

  logic h_wrap, v_wrap;
  logic hs0, vs0, de0;
  logic hs_dly, vs_dly, de_dly;

  // run_q holds off the first strobe so pix_ce is low in reset even for CLK_DIV=1
  always_comb begin
    pix_ce = run_q && (div_q == DIV_LAST);
    run_d  = 1'b1;
    div_d  = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
  end

  always_comb begin
    h_wrap = (h_q == H_LAST);
    v_wrap = (v_q == V_LAST);
    h_d    = h_q;
    v_d    = v_q;
    fc_d   = fc_q;
    if (pix_ce) begin
      h_d = h_wrap ? '0 : h_q + 1'b1;
      if (h_wrap) begin
        v_d = v_wrap ? '0 : v_q + 1'b1;
        if (v_wrap) fc_d = fc_q + 8'd1;
      end
    end
  end

  always_comb begin
    de0 = (h_q < H_ACT_C) && (v_q < V_ACT_C);
    hs0 = (h_q >= HS_BEG) && (h_q < HS_END);
    vs0 = (v_q >= VS_BEG) && (v_q < VS_END);
  end

  vga_sig_delay #(
    .WIDTH  (3),
    .DEPTH  (PIPE_LAT),
    .RST_VAL(3'b000)
  ) u_sig_delay (
    .clk  (clk),
    .clr_n(clr_n),
    .ce   (pix_ce),
    .d    ({hs0, vs0, de0}),
    .q    ({hs_dly, vs_dly, de_dly})
  );

  always_comb begin
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    de_d    = de_q;
    red_d   = red_q;
    green_d = green_q;
    blue_d  = blue_q;
    if (pix_ce) begin
      hsync_d = hs_dly ? HS_POL : ~HS_POL;
      vsync_d = vs_dly ? VS_POL : ~VS_POL;
      de_d    = de_dly;
      red_d   = de_dly ? i_red   : '0;
      green_d = de_dly ? i_green : '0;
      blue_d  = de_dly ? i_blue  : '0;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      div_q   <= '0;
      run_q   <= 1'b0;
      h_q     <= '0;
      v_q     <= '0;
      fc_q    <= '0;
      hsync_q <= ~HS_POL;
      vsync_q <= ~VS_POL;
      de_q    <= 1'b0;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else begin
      div_q   <= div_d;
      run_q   <= run_d;
      h_q     <= h_d;
      v_q     <= v_d;
      fc_q    <= fc_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
    end
  end

  assign h           = h_q;
  assign v           = v_q;
  assign line_start  = pix_ce && (h_q == '0);
  assign frame_start = line_start && (v_q == '0);
  assign frame_cnt   = fc_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign red         = red_q;
  assign green       = green_q;
  assign blue        = blue_q;

endmodule

// File: tb/tb_vga_timing_core.sv
// Bench for vga_timing_core: three parameterisations, one active at a time,
// checked every clock against a tick-index arithmetic model of the raster.
module tb_vga_timing_core;

  localparam int unsigned CW = 10;

  typedef struct packed {
    int h;
    int v;
    bit de;
    bit hs;
    bit vs;
  } pix_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clr_a = 1'b0, clr_b = 1'b0, clr_c = 1'b0;
  logic [2:0] i_red = '0, i_green = '0;
  logic [1:0] i_blue = '0;

  logic [CW-1:0] a_h, a_v, b_h, b_v, c_h, c_v;
  logic a_ce, a_ls, a_fs, a_hs, a_vs, a_de;
  logic b_ce, b_ls, b_fs, b_hs, b_vs, b_de;
  logic c_ce, c_ls, c_fs, c_hs, c_vs, c_de;
  logic [7:0] a_fc, b_fc, c_fc;
  logic [2:0] a_r, a_g, b_r, b_g, c_r, c_g;
  logic [1:0] a_b, b_b, c_b;

  vga_timing_core #(.PIPE_LAT(0)) u_a (
    .clk(clk), .clr_n(clr_a), .i_red(i_red), .i_green(i_green), .i_blue(i_blue),
    .h(a_h), .v(a_v), .pix_ce(a_ce), .line_start(a_ls), .frame_start(a_fs),
    .frame_cnt(a_fc), .hsync(a_hs), .vsync(a_vs), .de(a_de),
    .red(a_r), .green(a_g), .blue(a_b)
  );

  vga_timing_core #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b1), .CLK_DIV(3), .PIPE_LAT(2)
  ) u_b (
    .clk(clk), .clr_n(clr_b), .i_red(i_red), .i_green(i_green), .i_blue(i_blue),
    .h(b_h), .v(b_v), .pix_ce(b_ce), .line_start(b_ls), .frame_start(b_fs),
    .frame_cnt(b_fc), .hsync(b_hs), .vsync(b_vs), .de(b_de),
    .red(b_r), .green(b_g), .blue(b_b)
  );

  vga_timing_core #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0), .CLK_DIV(1), .PIPE_LAT(0)
  ) u_c (
    .clk(clk), .clr_n(clr_c), .i_red(i_red), .i_green(i_green), .i_blue(i_blue),
    .h(c_h), .v(c_v), .pix_ce(c_ce), .line_start(c_ls), .frame_start(c_fs),
    .frame_cnt(c_fc), .hsync(c_hs), .vsync(c_vs), .de(c_de),
    .red(c_r), .green(c_g), .blue(c_b)
  );

  int sel = 0;
  logic [CW-1:0] o_h, o_v;
  logic o_ce, o_ls, o_fs, o_hs, o_vs, o_de;
  logic [7:0] o_fc;
  logic [2:0] o_r, o_g;
  logic [1:0] o_b;

  always_comb begin
    o_h = a_h; o_v = a_v; o_ce = a_ce; o_ls = a_ls; o_fs = a_fs; o_fc = a_fc;
    o_hs = a_hs; o_vs = a_vs; o_de = a_de; o_r = a_r; o_g = a_g; o_b = a_b;
    case (sel)
      1: begin
        o_h = b_h; o_v = b_v; o_ce = b_ce; o_ls = b_ls; o_fs = b_fs; o_fc = b_fc;
        o_hs = b_hs; o_vs = b_vs; o_de = b_de; o_r = b_r; o_g = b_g; o_b = b_b;
      end
      2: begin
        o_h = c_h; o_v = c_v; o_ce = c_ce; o_ls = c_ls; o_fs = c_fs; o_fc = c_fc;
        o_hs = c_hs; o_vs = c_vs; o_de = c_de; o_r = c_r; o_g = c_g; o_b = c_b;
      end
      default: ;
    endcase
  end

  // active mode description
  int m_ha, m_hf, m_hs, m_hb, m_va, m_vf, m_vs, m_vb, m_div, m_pl;
  bit m_hpol, m_vpol;

  // bench state: clocks since release, pixel ticks taken, sampled colour
  int     cyc;
  longint ticks;
  bit     ce_pend;
  logic [2:0] pend_r, pend_g, lat_r, lat_g;
  logic [1:0] pend_b, lat_b;

  int npass = 0, nfail = 0, nchk = 0;

  function automatic pix_t model(input longint p);
    pix_t r;
    int ht, vt;
    ht = m_ha + m_hf + m_hs + m_hb;
    vt = m_va + m_vf + m_vs + m_vb;
    r = '0;
    if (p >= 0) begin
      r.h  = int'(p % longint'(ht));
      r.v  = int'((p / longint'(ht)) % longint'(vt));
      r.de = (r.h < m_ha) && (r.v < m_va);
      r.hs = (r.h >= m_ha + m_hf) && (r.h < m_ha + m_hf + m_hs);
      r.vs = (r.v >= m_va + m_vf) && (r.v < m_va + m_vf + m_vs);
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %0d expected %0d (mode %0d tick %0d)", tag, obs, exp, sel, ticks);
    end
  endtask

  task automatic set_mode(input int s);
    sel = s;
    case (s)
      0: begin
        m_ha = 640; m_hf = 16; m_hs = 96; m_hb = 48;
        m_va = 480; m_vf = 10; m_vs = 2;  m_vb = 33;
        m_div = 2; m_pl = 0; m_hpol = 1'b0; m_vpol = 1'b0;
      end
      1: begin
        m_ha = 16; m_hf = 2; m_hs = 3; m_hb = 2;
        m_va = 6;  m_vf = 1; m_vs = 2; m_vb = 1;
        m_div = 3; m_pl = 2; m_hpol = 1'b0; m_vpol = 1'b1;
      end
      default: begin
        m_ha = 8; m_hf = 1; m_hs = 2; m_hb = 1;
        m_va = 4; m_vf = 1; m_vs = 1; m_vb = 1;
        m_div = 1; m_pl = 0; m_hpol = 1'b1; m_vpol = 1'b0;
      end
    endcase
  endtask

  task automatic set_clr(input logic val);
    case (sel)
      0: clr_a = val;
      1: clr_b = val;
      default: clr_c = val;
    endcase
  endtask

  task automatic clear_state();
    cyc = 0; ticks = 0; ce_pend = 1'b0;
    lat_r = '0; lat_g = '0; lat_b = '0;
  endtask

  task automatic check_cycle();
    pix_t cur, pin;
    bit exp_ce;
    longint fr_len;
    fr_len = longint'(m_ha + m_hf + m_hs + m_hb) * longint'(m_va + m_vf + m_vs + m_vb);
    exp_ce = (cyc >= 1) && ((cyc % m_div) == m_div - 1);
    cur = model(ticks);
    pin = model(ticks - 1 - longint'(m_pl));
    chk("pix_ce", 32'(o_ce), 32'(exp_ce));
    chk("h", 32'(o_h), 32'(cur.h));
    chk("v", 32'(o_v), 32'(cur.v));
    chk("line_start", 32'(o_ls), 32'(exp_ce && cur.h == 0));
    chk("frame_start", 32'(o_fs), 32'(exp_ce && cur.h == 0 && cur.v == 0));
    chk("frame_cnt", 32'(o_fc), 32'((ticks / fr_len) % 256));
    chk("hsync", 32'(o_hs), 32'(pin.hs ? m_hpol : !m_hpol));
    chk("vsync", 32'(o_vs), 32'(pin.vs ? m_vpol : !m_vpol));
    chk("de", 32'(o_de), 32'(pin.de));
    chk("red", 32'(o_r), 32'(pin.de ? lat_r : 3'd0));
    chk("green", 32'(o_g), 32'(pin.de ? lat_g : 3'd0));
    chk("blue", 32'(o_b), 32'(pin.de ? lat_b : 2'd0));
    ce_pend = exp_ce;
  endtask

  // On strobe cycles present the colour for the pixel PIPE_LAT ticks back:
  // red carries x&7, green/blue are random. Other cycles carry junk.
  task automatic drive();
    pix_t src;
    if (ce_pend) begin
      src = model(ticks - longint'(m_pl));
      i_red   = 3'(src.h);
      i_green = 3'($urandom);
      i_blue  = 2'($urandom);
      pend_r = i_red; pend_g = i_green; pend_b = i_blue;
    end else begin
      i_red   = 3'($urandom);
      i_green = 3'($urandom);
      i_blue  = 2'($urandom);
    end
  endtask

  task automatic step();
    check_cycle();
    drive();
    @(posedge clk);
    if (ce_pend) begin
      ticks++;
      lat_r = pend_r; lat_g = pend_g; lat_b = pend_b;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic start_phase(input int s);
    set_mode(s);
    @(negedge clk);
    clear_state();
    check_cycle();
    set_clr(1'b1);
  endtask

  task automatic reset_at(input int th, input int tv, input int budget);
    pix_t cur;
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      cur = model(ticks);
      if (cur.h == th && cur.v == tv) hit = 1'b1;
      else step();
    end
    chk("reached_reset_point", 32'(hit), 32'd1);
    #1;
    set_clr(1'b0);
    #1;
    chk("rst_hsync", 32'(o_hs), 32'(!m_hpol));
    chk("rst_vsync", 32'(o_vs), 32'(!m_vpol));
    chk("rst_de", 32'(o_de), 32'd0);
    chk("rst_rgb", 32'({o_r, o_g, o_b}), 32'd0);
    chk("rst_h", 32'(o_h), 32'd0);
    chk("rst_v", 32'(o_v), 32'd0);
    chk("rst_frame_cnt", 32'(o_fc), 32'd0);
    chk("rst_pix_ce", 32'(o_ce), 32'd0);
    chk("rst_line_start", 32'(o_ls), 32'd0);
    @(negedge clk);
    clear_state();
    check_cycle();
    set_clr(1'b1);
  endtask

  initial begin
    repeat (3) @(negedge clk);

    // 640x480 defaults: two full lines, reset near h=300 of line 2, restart
    start_phase(0);
    reset_at(int'($urandom_range(250, 350)), 2, 8000);
    run(1700);
    clr_a = 1'b0;

    // small mode, PIPE_LAT=2, CLK_DIV=3: several frames, random mid-frame reset
    start_phase(1);
    run(2100);
    reset_at(int'($urandom_range(0, 22)), int'($urandom_range(0, 9)), 800);
    run(800);
    clr_b = 1'b0;

    // tiny mode, CLK_DIV=1, active-high hsync: run past the 256-frame wrap
    start_phase(2);
    run(257 * 84 + 30);
    clr_c = 1'b0;

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
